// File: rtl/mcpu_ctrl_hs.sv
// mcpu_ctrl_hs: multi-cycle control sequencer for the MCPU datapath.
// Handshakes with memory via mem_req/mem_ready, enters a sticky FAULT
// state on illegal opcodes or when a memory access waits too long.
// Optional JAL link path is compiled in when MCPU_JAL_EN is defined.
module mcpu_ctrl_hs #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       pc_we,
  output logic       ir_we,
  output logic       a_we,
  output logic       b_we,
  output logic       ben,
  output logic       reg_we,
  output logic       memin,
  output logic       dst,
  output logic       jal,
  output logic [1:0] regin,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       fault
);

  // Wait counter must hold MEM_TIMEOUT-1; keep at least one bit when disabled.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : CW'(0);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12,
`ifdef MCPU_JAL_EN
    JAL_LINK = 4'd13,
`endif
    FAULT    = 4'd15
  } state_t;

  state_t          state_r;
  state_t          next_s;
  logic [CW-1:0]   wait_r;
  logic            mem_state_s;
  logic            timeout_s;

  // Flag the states that hold a memory request open and detect an expired wait.
  always_comb begin
    mem_state_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    if (MEM_TIMEOUT > 0) begin
      timeout_s = mem_state_s && !mem_ready && (wait_r == WAIT_LAST);
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state selection; any unknown state code falls into FAULT.
  always_comb begin
    next_s = state_r;
    case (state_r)
      FETCH: begin
        if (timeout_s)      next_s = FAULT;
        else if (mem_ready) next_s = DECODE;
        else                next_s = FETCH;
      end
      DECODE: begin
        case (opcode)
          6'h00: begin
            if ((funct == 6'h20) || (funct == 6'h22) || (funct == 6'h2A)) next_s = EXEC_R;
            else if (funct == 6'h08)                                       next_s = JR;
            else                                                           next_s = FAULT;
          end
          6'h23, 6'h2B: next_s = MEM_ADDR;
          6'h04, 6'h05: next_s = BRANCH;
          6'h02:        next_s = JUMP;
`ifdef MCPU_JAL_EN
          6'h03:        next_s = JAL_LINK;
`else
          6'h03:        next_s = FAULT;
`endif
          6'h08:        next_s = EXEC_I;
          default:      next_s = FAULT;
        endcase
      end
      EXEC_R:   next_s = WB_R;
      WB_R:     next_s = FETCH;
      EXEC_I:   next_s = WB_I;
      WB_I:     next_s = FETCH;
      MEM_ADDR: begin
        if (opcode == 6'h23) next_s = MEM_RD;
        else                 next_s = MEM_WR;
      end
      MEM_RD: begin
        if (timeout_s)      next_s = FAULT;
        else if (mem_ready) next_s = WB_MEM;
        else                next_s = MEM_RD;
      end
      WB_MEM:   next_s = FETCH;
      MEM_WR: begin
        if (timeout_s)      next_s = FAULT;
        else if (mem_ready) next_s = FETCH;
        else                next_s = MEM_WR;
      end
      BRANCH:   next_s = FETCH;
      JUMP:     next_s = FETCH;
      JR:       next_s = FETCH;
`ifdef MCPU_JAL_EN
      JAL_LINK: next_s = FETCH;
`endif
      FAULT:    next_s = FAULT;
      default:  next_s = FAULT;
    endcase
  end

  // State register and memory wait counter (cleared on every state change).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
      wait_r  <= CW'(0);
    end else begin
      state_r <= next_s;
      if (next_s != state_r) begin
        wait_r <= CW'(0);
      end else if (mem_state_s && !mem_ready && (MEM_TIMEOUT > 0)) begin
        wait_r <= wait_r + CW'(1);
      end else begin
        wait_r <= wait_r;
      end
    end
  end

  assign state = state_r;

  // Output decode from the current state; reset suppresses every enable.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    ben     = 1'b0;
    reg_we  = 1'b0;
    memin   = 1'b0;
    dst     = 1'b0;
    jal     = 1'b0;
    regin   = 2'd0;
    alusrca = 2'd0;
    alusrcb = 2'd0;
    aluop   = 3'd0;
    pcsrc   = 2'd0;
    fault   = 1'b0;
    if (reset) begin
      fault = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'd3;
          pcsrc   = 2'd2;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        DECODE: begin
          a_we = 1'b1;
          b_we = 1'b1;
          ben  = 1'b1;
        end
        EXEC_R: begin
          alusrca = 2'd1;
          alusrcb = 2'd2;
          case (funct)
            6'h22:   aluop = 3'd1;
            6'h2A:   aluop = 3'd3;
            default: aluop = 3'd0;
          endcase
        end
        WB_R: begin
          reg_we = 1'b1;
          regin  = 2'd1;
        end
        EXEC_I, MEM_ADDR: begin
          alusrca = 2'd1;
          alusrcb = 2'd1;
        end
        WB_I: begin
          reg_we = 1'b1;
          dst    = 1'b1;
          regin  = 2'd1;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          memin   = 1'b1;
        end
        WB_MEM: begin
          reg_we = 1'b1;
          dst    = 1'b1;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          memin   = 1'b1;
        end
        BRANCH: begin
          alusrca = 2'd1;
          alusrcb = 2'd2;
          aluop   = 3'd1;
          if (opcode == 6'h04) pc_we = zero;
          else                 pc_we = ~zero;
        end
        JUMP: begin
          pc_we = 1'b1;
          pcsrc = 2'd1;
        end
        JR: begin
          alusrca = 2'd1;
          alusrcb = 2'd2;
          pcsrc   = 2'd2;
          pc_we   = 1'b1;
        end
`ifdef MCPU_JAL_EN
        JAL_LINK: begin
          reg_we = 1'b1;
          jal    = 1'b1;
          regin  = 2'd2;
          pc_we  = 1'b1;
          pcsrc  = 2'd1;
        end
`endif
        FAULT:   fault = 1'b1;
        default: fault = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl_hs.sv
// Randomized bench for mcpu_ctrl_hs: a per-instruction model builds the
// expected sequence of state codes and outputs (including memory waits,
// timeouts and illegal encodings) and the DUT is compared cycle by cycle.
module tb_mcpu_ctrl_hs;

  localparam int TMO = 4;
  localparam logic [22:0] EN_MASK = 23'b11111111_0_0_0_00_00_00_000_00_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, pc_we, ir_we, a_we, b_we, ben, reg_we;
  logic       memin, dst, jal, fault;
  logic [1:0] regin, alusrca, alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;
  logic [22:0] obs;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       rdy;
  } item_t;

  item_t q[$];

  mcpu_ctrl_hs #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .pc_we(pc_we),
    .ir_we(ir_we), .a_we(a_we), .b_we(b_we), .ben(ben), .reg_we(reg_we),
    .memin(memin), .dst(dst), .jal(jal), .regin(regin), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, pc_we, ir_we, a_we, b_we, ben, reg_we,
                memin, dst, jal, regin, alusrca, alusrcb, aluop, pcsrc, fault};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic logic [22:0] exp_out(input logic [3:0] c, input logic rdy,
                                          input logic zr, input logic [5:0] op,
                                          input logic [5:0] fn);
    logic mreq = 1'b0, mwe = 1'b0, pcw = 1'b0, irw = 1'b0, aw = 1'b0, bw = 1'b0;
    logic bn = 1'b0, rw = 1'b0, mi = 1'b0, ds = 1'b0, jl = 1'b0, fl = 1'b0;
    logic [1:0] rin = 2'd0, asa = 2'd0, asb = 2'd0, ps = 2'd0;
    logic [2:0] aop = 3'd0;
    case (c)
      4'd0:  begin mreq = 1'b1; asb = 2'd3; ps = 2'd2; irw = rdy; pcw = rdy; end
      4'd1:  begin aw = 1'b1; bw = 1'b1; bn = 1'b1; end
      4'd2:  begin asa = 2'd1; asb = 2'd2;
                   aop = (fn == 6'h22) ? 3'd1 : ((fn == 6'h2A) ? 3'd3 : 3'd0); end
      4'd3:  begin rw = 1'b1; rin = 2'd1; end
      4'd4:  begin asa = 2'd1; asb = 2'd1; end
      4'd5:  begin rw = 1'b1; ds = 1'b1; rin = 2'd1; end
      4'd6:  begin asa = 2'd1; asb = 2'd1; end
      4'd7:  begin mreq = 1'b1; mi = 1'b1; end
      4'd8:  begin rw = 1'b1; ds = 1'b1; end
      4'd9:  begin mreq = 1'b1; mwe = 1'b1; mi = 1'b1; end
      4'd10: begin asa = 2'd1; asb = 2'd2; aop = 3'd1; pcw = (op == 6'h04) ? zr : ~zr; end
      4'd11: begin pcw = 1'b1; ps = 2'd1; end
      4'd12: begin asa = 2'd1; asb = 2'd2; ps = 2'd2; pcw = 1'b1; end
      4'd13: begin rw = 1'b1; jl = 1'b1; rin = 2'd2; pcw = 1'b1; ps = 2'd1; end
      4'd15: fl = 1'b1;
      default: fl = 1'b0;
    endcase
    return {mreq, mwe, pcw, irw, aw, bw, bn, rw, mi, ds, jl, rin, asa, asb, aop, ps, fl};
  endfunction

  task automatic push_one(input logic [3:0] c);
    item_t it;
    it.code = c;
    it.rdy  = 1'($urandom_range(0, 1));
    q.push_back(it);
  endtask

  // A memory phase: 'waits' not-ready cycles, then ready; too many waits time out.
  task automatic push_mem(input logic [3:0] c, input int waits, output bit ok);
    item_t it;
    it.code = c;
    it.rdy  = 1'b0;
    if (waits >= TMO) begin
      for (int i = 0; i < TMO; i++) q.push_back(it);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < waits; i++) q.push_back(it);
      it.rdy = 1'b1;
      q.push_back(it);
      ok = 1'b1;
    end
  endtask

  // Build the expected cycle sequence of one instruction.
  task automatic plan_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int wf, input int wm, output bit faulted);
    bit ok;
    q.delete();
    faulted = 1'b0;
    push_mem(4'd0, wf, ok);
    if (!ok) begin
      faulted = 1'b1;
    end else begin
      push_one(4'd1);
      case (op)
        6'h00: begin
          if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin
            push_one(4'd2); push_one(4'd3);
          end else if (fn == 6'h08) begin
            push_one(4'd12);
          end else begin
            faulted = 1'b1;
          end
        end
        6'h23: begin
          push_one(4'd6);
          push_mem(4'd7, wm, ok);
          if (ok) push_one(4'd8);
          else    faulted = 1'b1;
        end
        6'h2B: begin
          push_one(4'd6);
          push_mem(4'd9, wm, ok);
          if (!ok) faulted = 1'b1;
        end
        6'h04, 6'h05: push_one(4'd10);
        6'h02: push_one(4'd11);
`ifdef MCPU_JAL_EN
        6'h03: push_one(4'd13);
`else
        6'h03: faulted = 1'b1;
`endif
        6'h08: begin push_one(4'd4); push_one(4'd5); end
        default: faulted = 1'b1;
      endcase
    end
    if (faulted) begin
      for (int i = 0; i < 3; i++) push_one(4'd15);
    end
  endtask

  task automatic apply(input item_t it, input logic [5:0] op, input logic [5:0] fn,
                       input logic zr);
    @(negedge clk);
    reset     = 1'b0;
    opcode    = op;
    funct     = fn;
    zero      = zr;
    mem_ready = it.rdy;
    #1;
    check_eq($sformatf("state op%0h", op), {28'd0, state}, {28'd0, it.code});
    check_eq($sformatf("outs op%0h st%0d", op, it.code), {9'd0, obs},
             {9'd0, exp_out(it.code, it.rdy, zr, op, fn)});
  endtask

  task automatic reset_cycle(input string tag);
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    #1;
    check_eq(tag, {9'd0, obs & EN_MASK}, 32'd0);
  endtask

  logic [5:0] op_tab [0:11] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04,
                                6'h05, 6'h02, 6'h03, 6'h08, 6'h3F, 6'h00};
  logic [5:0] fn_tab [0:4]  = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00};

  initial begin
    bit faulted;
    bit aborted;
    logic [5:0] op, fn;
    logic zr;
    int wf, wm, pick;

    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0; mem_ready = 1'b0;
    reset_cycle("rst_en0");
    reset_cycle("rst_en1");

    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 12);
      if (pick == 12) op = 6'($urandom);
      else            op = op_tab[pick];
      pick = $urandom_range(0, 5);
      if (pick == 5) fn = 6'($urandom);
      else           fn = fn_tab[pick];
      if (n == 0) begin op = 6'h00; fn = 6'h20; end
      zr = 1'($urandom_range(0, 1));
      wf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
      wm = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      if (n == 0) begin wf = 0; wm = 0; end
      plan_instr(op, fn, wf, wm, faulted);
      aborted = 1'b0;
      foreach (q[i]) begin
        if (!aborted) begin
          if (i > 0 && !faulted && $urandom_range(0, 39) == 0) begin
            reset_cycle("abort_en");
            aborted = 1'b1;
          end else begin
            apply(q[i], op, fn, zr);
          end
        end
      end
      if (faulted && !aborted) reset_cycle("fault_rst_en");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
